// File: rtl/bist_err_log_pkg.sv
// Shared record layout and state encodings for the BIST error log.
// A record packs {cs, addr, cycle, error_code} with error_code in the LSBs.
package bist_err_log_pkg;

  localparam int CS_W  = 2;
  localparam int AD_W  = 17;
  localparam int CYC_W = 3;
  localparam int EC_W  = 4;
  localparam int REC_W = CS_W + AD_W + CYC_W + EC_W;

  localparam int EC_LSB  = 0;
  localparam int CYC_LSB = EC_LSB + EC_W;
  localparam int AD_LSB  = CYC_LSB + CYC_W;
  localparam int CS_LSB  = AD_LSB + AD_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  function automatic logic [REC_W-1:0] make_rec(input logic [CS_W-1:0]  cs,
                                                input logic [AD_W-1:0]  ad,
                                                input logic [CYC_W-1:0] cyc,
                                                input logic [EC_W-1:0]  ec);
    return {cs, ad, cyc, ec};
  endfunction

endpackage

// File: rtl/bist_log_ram.sv
// Log storage: one write port and one registered read port, no reset.
// A read and write to the same address in one cycle returns the old contents.
module bist_log_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 26
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/bist_err_log.sv
// Fail-record logger behind the March-C result stage: circular log, saturating
// fail counter, sticky overflow and first-fail capture, drained via a pop port.
module bist_err_log
  import bist_err_log_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  input  logic             rec_valid,
  input  logic [REC_W-1:0] rec_in,
  input  logic             test_done,
  input  logic             rd_req,
  output logic             rd_valid,
  output logic [REC_W-1:0] rd_data,
  output logic [AW:0]      log_count,
  output logic             log_empty,
  output logic             log_full,
  output logic [CNT_W-1:0] err_total,
  output logic             overflow,
  output logic [REC_W-1:0] first_rec,
  output logic             first_vld,
  output logic [1:0]       state
);

  state_t           state_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic [CNT_W-1:0] err_total_r;
  logic             overflow_r;
  logic [REC_W-1:0] first_rec_r;
  logic             first_vld_r;
  logic             rd_valid_r;
  logic [REC_W-1:0] ram_q_s;

  logic flush_s;
  logic cap_s;
  logic pop_s;
  logic wr_s;
  logic drop_s;

  assign log_empty = (count_r == {(AW+1){1'b0}});
  assign log_full  = (count_r == (AW+1)'(DEPTH));

  // start only flushes when it actually causes a transition into CAPTURE.
  assign flush_s = clear | (start & (state_r != ST_CAPTURE));
  assign cap_s   = (state_r == ST_CAPTURE) & rec_valid & ~clear;
  assign pop_s   = rd_req & ~log_empty & ~clear & ~start;
  assign wr_s    = cap_s & (~log_full | pop_s);
  assign drop_s  = cap_s & log_full & ~pop_s;

  bist_log_ram #(.DEPTH(DEPTH), .AW(AW), .W(REC_W)) u_ram (
    .clk   (clk),
    .we    (wr_s),
    .waddr (wr_ptr_r),
    .wdata (rec_in),
    .re    (pop_s),
    .raddr (rd_ptr_r),
    .rdata (ram_q_s)
  );

  // FSM, pointers, counters and capture registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {(AW+1){1'b0}};
      err_total_r <= {CNT_W{1'b0}};
      overflow_r  <= 1'b0;
      first_rec_r <= {REC_W{1'b0}};
      first_vld_r <= 1'b0;
      rd_valid_r  <= 1'b0;
    end else begin
      if (clear) begin
        state_r <= ST_IDLE;
      end else begin
        case (state_r)
          ST_IDLE:    if (start) state_r <= ST_CAPTURE;
          ST_CAPTURE: if (test_done) state_r <= ST_DONE;
          ST_DONE:    if (start) state_r <= ST_CAPTURE;
          default:    state_r <= ST_IDLE;
        endcase
      end

      if (flush_s) begin
        wr_ptr_r    <= {AW{1'b0}};
        rd_ptr_r    <= {AW{1'b0}};
        count_r     <= {(AW+1){1'b0}};
        err_total_r <= {CNT_W{1'b0}};
        overflow_r  <= 1'b0;
        first_vld_r <= 1'b0;
        rd_valid_r  <= 1'b0;
      end else begin
        rd_valid_r <= pop_s;
        if (wr_s) begin
          wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
        end
        if (wr_s && !pop_s) begin
          count_r <= count_r + {{AW{1'b0}}, 1'b1};
        end else if (pop_s && !wr_s) begin
          count_r <= count_r - {{AW{1'b0}}, 1'b1};
        end
        if (cap_s && (err_total_r != {CNT_W{1'b1}})) begin
          err_total_r <= err_total_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (cap_s && !first_vld_r) begin
          first_rec_r <= rec_in;
          first_vld_r <= 1'b1;
        end
        if (drop_s) begin
          overflow_r <= 1'b1;
        end
      end
    end
  end

  // RAM read register has no reset, so data is masked outside a valid beat.
  assign rd_data   = rd_valid_r ? ram_q_s : {REC_W{1'b0}};
  assign rd_valid  = rd_valid_r;
  assign log_count = count_r;
  assign err_total = err_total_r;
  assign overflow  = overflow_r;
  assign first_rec = first_rec_r;
  assign first_vld = first_vld_r;
  assign state     = state_r;

endmodule

// File: tb/tb_bist_err_log.sv
// Directed self-checking bench for bist_err_log; a second instance with a
// 3-bit fail counter shares all inputs so saturation is reachable quickly.
module tb_bist_err_log;
  import bist_err_log_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             start, clear, rec_valid, test_done, rd_req;
  logic [REC_W-1:0] rec_in;
  logic             rd_valid, log_empty, log_full, overflow, first_vld;
  logic [REC_W-1:0] rd_data, first_rec;
  logic [4:0]       log_count;
  logic [19:0]      err_total;
  logic [1:0]       state;

  logic             s_rd_valid, s_log_empty, s_log_full, s_overflow, s_first_vld;
  logic [REC_W-1:0] s_rd_data, s_first_rec;
  logic [4:0]       s_log_count;
  logic [2:0]       s_err_total;
  logic [1:0]       s_state;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bist_err_log dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .rec_valid(rec_valid),
    .rec_in(rec_in), .test_done(test_done), .rd_req(rd_req), .rd_valid(rd_valid),
    .rd_data(rd_data), .log_count(log_count), .log_empty(log_empty), .log_full(log_full),
    .err_total(err_total), .overflow(overflow), .first_rec(first_rec),
    .first_vld(first_vld), .state(state)
  );

  bist_err_log #(.DEPTH(16), .AW(4), .CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .rec_valid(rec_valid),
    .rec_in(rec_in), .test_done(test_done), .rd_req(rd_req), .rd_valid(s_rd_valid),
    .rd_data(s_rd_data), .log_count(s_log_count), .log_empty(s_log_empty),
    .log_full(s_log_full), .err_total(s_err_total), .overflow(s_overflow),
    .first_rec(s_first_rec), .first_vld(s_first_vld), .state(s_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic push(input logic [REC_W-1:0] r);
    rec_valid = 1'b1; rec_in = r; tick(); rec_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; clear = 1'b0; rec_valid = 1'b0;
    test_done = 1'b0; rd_req = 1'b0; rec_in = '0;
    tick(); tick();
    if (state !== 2'd0)  begin miscompares++; $display("FAIL rst_state: got %0d expected 0", state); end
    if (log_count !== 5'd0) begin miscompares++; $display("FAIL rst_count: got %0d expected 0", log_count); end
    if (log_empty !== 1'b1) begin miscompares++; $display("FAIL rst_empty: got %0b expected 1", log_empty); end
    if ({rd_valid, overflow, first_vld} !== 3'b000) begin
      miscompares++; $display("FAIL rst_flags: got %03b expected 000", {rd_valid, overflow, first_vld});
    end
    if (err_total !== 20'd0 || rd_data !== 26'd0 || first_rec !== 26'd0) begin
      miscompares++; $display("FAIL rst_data: got %0h/%0h/%0h expected 0", err_total, rd_data, first_rec);
    end
    vectors += 5;
    reset = 1'b1; tick();
  endtask

  task automatic test_basic();
    pulse_start();
    chk("basic_state_cap", 32'(state), 32'd1);
    for (int i = 1; i <= 3; i++) push(26'(i));
    test_done = 1'b1; tick(); test_done = 1'b0;
    chk("basic_state_done", 32'(state), 32'd2);
    chk("basic_err_total", 32'(err_total), 32'd3);
    chk("basic_count", 32'(log_count), 32'd3);
    chk("basic_first_rec", 32'(first_rec), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      rd_req = 1'b1; tick(); rd_req = 1'b0;
      chk("basic_rd_valid", 32'(rd_valid), 32'd1);
      chk("basic_rd_data", 32'(rd_data), 32'(i));
    end
    tick();
    chk("basic_rd_valid_off", 32'(rd_valid), 32'd0);
    chk("basic_empty", 32'(log_empty), 32'd1);
  endtask

  task automatic test_overflow();
    pulse_start();
    for (int i = 0; i < 20; i++) push(26'(i));
    chk("ovf_full", 32'(log_full), 32'd1);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_err_total", 32'(err_total), 32'd20);
    chk("ovf_count", 32'(log_count), 32'd16);
    chk("ovf_first_rec", 32'(first_rec), 32'd0);
    rd_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("ovf_rd_valid", 32'(rd_valid), 32'd1);
      chk("ovf_rd_data", 32'(rd_data), 32'(i));
    end
    rd_req = 1'b0; tick();
    chk("ovf_empty", 32'(log_empty), 32'd1);
  endtask

  task automatic test_full_same_cycle();
    clear = 1'b1; tick(); clear = 1'b0;
    pulse_start();
    for (int i = 0; i < 16; i++) push(26'(12'h200 + i));
    chk("fsc_full", 32'(log_full), 32'd1);
    rec_valid = 1'b1; rec_in = 26'h300; rd_req = 1'b1; tick();
    rec_valid = 1'b0; rd_req = 1'b0;
    chk("fsc_count", 32'(log_count), 32'd16);
    chk("fsc_overflow", 32'(overflow), 32'd0);
    chk("fsc_rd_data", 32'(rd_data), 32'h200);
    chk("fsc_err_total", 32'(err_total), 32'd17);
    rd_req = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("fsc_drain", 32'(rd_data), (i == 16) ? 32'h300 : 32'(12'h200 + i));
    end
    rd_req = 1'b0; tick();
  endtask

  task automatic test_empty_read();
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    chk("empty_rd_valid", 32'(rd_valid), 32'd0);
    rec_valid = 1'b1; rec_in = 26'h0ABCDE; rd_req = 1'b1; tick();
    rec_valid = 1'b0; rd_req = 1'b0;
    chk("empty_wr_count", 32'(log_count), 32'd1);
    chk("empty_wr_rd_valid", 32'(rd_valid), 32'd0);
    tick();
    chk("empty_wr_rd_valid2", 32'(rd_valid), 32'd0);
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    chk("empty_pop_data", 32'(rd_data), 32'h0ABCDE);
  endtask

  task automatic test_idle_done();
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_state", 32'(state), 32'd0);
    chk("clr_err_total", 32'(err_total), 32'd0);
    push(26'h1);
    chk("idle_ignore_err", 32'(err_total), 32'd0);
    chk("idle_ignore_count", 32'(log_count), 32'd0);
    pulse_start();
    for (int i = 0; i < 4; i++) push(make_rec(2'd1, 17'(i), 3'd2, 4'h5));
    rec_valid = 1'b1; rec_in = 26'h7; test_done = 1'b1; tick();
    rec_valid = 1'b0; test_done = 1'b0;
    chk("done_state", 32'(state), 32'd2);
    chk("done_err_total", 32'(err_total), 32'd5);
    chk("done_first_rec", 32'(first_rec), 32'(make_rec(2'd1, 17'd0, 3'd2, 4'h5)));
    push(26'h9);
    chk("done_ignore_err", 32'(err_total), 32'd5);
    chk("done_ignore_count", 32'(log_count), 32'd5);
    pulse_start();
    chk("restart_count", 32'(log_count), 32'd0);
    chk("restart_err", 32'(err_total), 32'd0);
    chk("restart_flags", 32'({overflow, first_vld}), 32'd0);
    chk("restart_state", 32'(state), 32'd1);
  endtask

  task automatic test_saturate_and_reset();
    for (int i = 0; i < 9; i++) push(26'(i + 40));
    chk("sat_small", 32'(s_err_total), 32'd7);
    chk("sat_main", 32'(err_total), 32'd9);
    #2 reset = 1'b0;
    #1;
    chk("areset_state", 32'(state), 32'd0);
    chk("areset_count", 32'(log_count), 32'd0);
    chk("areset_empty", 32'(log_empty), 32'd1);
    chk("areset_err", 32'(err_total), 32'd0);
    chk("areset_small_err", 32'(s_err_total), 32'd0);
    chk("areset_flags", 32'({first_vld, overflow, rd_valid}), 32'd0);
    chk("areset_first_rec", 32'(first_rec), 32'd0);
    tick(); reset = 1'b1; tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_same_cycle();
    test_empty_read();
    test_idle_done();
    test_saturate_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
